// File: rtl/sram_pkg.sv
// Shared SRAM timing definitions used by both the controller and the responder,
// so the two ends agree on access-state encoding and wait-state count.
package sram_pkg;

    localparam int CNT_W             = 3;
    localparam int ACCESS_CYCLES_DEF = 6;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_HOLD,
        RD_WAIT,
        RD_DRIVE
    } state_t;

endpackage

// File: rtl/sram_responder_if.sv
// Request/status bundle between the SRAM controller (master) and the device model (slave).
// DQ is a tristate pin, so it is carried as a plain inout port rather than here.
interface sram_responder_if #(
    parameter int ADDR_W = 10
);
    logic              sram_ce_n;
    logic              sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic              rd_valid;
    logic              acc_done;

    modport master (
        output sram_ce_n, sram_we_n, sram_addr,
        input  rd_valid, acc_done
    );

    modport slave (
        input  sram_ce_n, sram_we_n, sram_addr,
        output rd_valid, acc_done
    );
endinterface

// File: rtl/sram_resp_timer.sv
// Wait-state counter: load to 1 on a new access, count stable cycles, hold at terminal count.
// Single-cycle response; the terminal flag is a pure decode of the count register.
module sram_resp_timer
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(ACCESS_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(1);
        end else if (inc_i && !tc_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/sram_responder.sv
// Asynchronous-SRAM device model: commits a write or drives read data only after ACCESS_CYCLES
// consecutive stable request cycles; no backpressure, any request change aborts and restarts.
module sram_responder
    import sram_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 10,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sram_responder_if.slave   bus,
    inout  wire  [DATA_W-1:0] sram_dq
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state_q;
    logic [ADDR_W:0]   req_q;
    logic [ADDR_W:0]   req_cur;
    logic [DATA_W-1:0] dout_q;
    logic              dq_oe_q;
    logic              rd_valid_q;
    logic              acc_done_q;

    logic active, stable, tc, wr_en;
    logic tmr_clr, tmr_load, tmr_inc;

    assign req_cur  = {bus.sram_we_n, bus.sram_addr};
    assign active   = (state_q != IDLE);
    assign stable   = !bus.sram_ce_n && (req_cur == req_q);
    assign tmr_clr  = active && bus.sram_ce_n;
    assign tmr_load = !bus.sram_ce_n && (!active || !stable);
    assign tmr_inc  = active && stable;
    assign wr_en    = (state_q == WR_WAIT) && stable && tc;

    sram_resp_timer #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tmr_clr),
        .load_i (tmr_load),
        .inc_i  (tmr_inc),
        .tc_o   (tc)
    );

    // Storage is not reset; a write only fires from WR_WAIT, which reset forces out of.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.sram_addr] <= sram_dq;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            dout_q     <= '0;
            dq_oe_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            acc_done_q <= 1'b0;
        end else begin
            acc_done_q <= 1'b0;
            if (!active) begin
                if (!bus.sram_ce_n) begin
                    req_q   <= req_cur;
                    state_q <= bus.sram_we_n ? RD_WAIT : WR_WAIT;
                end
            end else if (bus.sram_ce_n) begin
                state_q    <= IDLE;
                dq_oe_q    <= 1'b0;
                rd_valid_q <= 1'b0;
            end else if (!stable) begin
                // New tuple restarts immediately; this is also the read-to-write turnaround.
                req_q      <= req_cur;
                state_q    <= bus.sram_we_n ? RD_WAIT : WR_WAIT;
                dq_oe_q    <= 1'b0;
                rd_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    WR_WAIT: begin
                        if (tc) begin
                            state_q    <= WR_HOLD;
                            acc_done_q <= 1'b1;
                        end
                    end
                    RD_WAIT: begin
                        if (tc) begin
                            state_q    <= RD_DRIVE;
                            dout_q     <= mem[bus.sram_addr];
                            dq_oe_q    <= 1'b1;
                            rd_valid_q <= 1'b1;
                            acc_done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sram_dq      = dq_oe_q ? dout_q : 'z;
    assign bus.rd_valid = rd_valid_q;
    assign bus.acc_done = acc_done_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: stimulus pushes expected acc_done events into a queue,
// a negedge monitor pops and checks cycle, read data and rd_valid.
module tb_sram_responder;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int ACC    = 6;

    typedef struct {
        bit          rd;
        int          cyc;
        logic [15:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic tb_oe;
    logic [DATA_W-1:0] tb_dat;
    wire  [DATA_W-1:0] sram_dq;

    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    sram_responder_if #(.ADDR_W(ADDR_W)) bus ();

    sram_responder #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .ACCESS_CYCLES (ACC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sram_dq (sram_dq)
    );

    assign sram_dq = tb_oe ? tb_dat : 'z;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input bit rd, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                         input bit expect_done);
        exp_t e;
        bus.sram_ce_n = 1'b0;
        bus.sram_we_n = rd;
        bus.sram_addr = a;
        tb_oe         = !rd;
        tb_dat        = d;
        if (expect_done) begin
            e.rd  = rd;
            e.cyc = cyc + ACC;
            e.dat = d;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        bus.sram_ce_n = 1'b1;
        bus.sram_we_n = 1'b1;
        tb_oe         = 1'b0;
        step(n);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input int hold);
        start(1'b0, a, d, 1'b1);
        step(hold);
        idle(2);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        start(1'b1, a, d, 1'b1);
        step(ACC);
        idle(2);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.acc_done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_acc_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("acc_done_cycle", e.cyc, e.cyc == cyc ? e.cyc : cyc + 32'h1000_0000);
                chk("acc_done_cycle_abs", cyc, e.cyc);
                if (e.rd) begin
                    chk("rd_data", {16'h0, sram_dq}, {16'h0, e.dat});
                    chk("rd_valid_at_done", {31'h0, bus.rd_valid}, 32'd1);
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst           = 1'b0;
        bus.sram_ce_n = 1'b0;
        bus.sram_we_n = 1'b0;
        bus.sram_addr = 10'h005;
        tb_oe         = 1'b1;
        tb_dat        = 16'h0005;

        // Reset held with a write request pending: nothing may happen
        repeat (3) begin
            @(negedge clk);
            chk("rst_rd_valid", {31'h0, bus.rd_valid}, 32'd0);
            chk("rst_acc_done", {31'h0, bus.acc_done}, 32'd0);
            chk("rst_dq_undriven", {16'h0, sram_dq}, 32'h0005);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        e.rd = 1'b0; e.cyc = cyc + ACC; e.dat = 16'h0005;
        q.push_back(e);
        step(ACC);
        idle(2);

        // Preload
        wr(10'h040, 16'h0000, ACC);
        wr(10'h001, 16'h00C3, ACC);
        wr(10'h010, 16'h1010, ACC);
        wr(10'h011, 16'h1111, ACC);

        // Write then read, with latency probe one cycle before data
        wr(10'h12A, 16'hBEEF, ACC);
        start(1'b1, 10'h12A, 16'hBEEF, 1'b1);
        step(ACC - 1);
        chk("rd_valid_early", {31'h0, bus.rd_valid}, 32'd0);
        step(1);
        chk("rd_valid_on_time", {31'h0, bus.rd_valid}, 32'd1);
        chk("rd_dq_held", {16'h0, sram_dq}, 32'h0000BEEF);
        step(2);
        chk("rd_dq_still_held", {16'h0, sram_dq}, 32'h0000BEEF);
        idle(1);
        chk("rd_valid_released", {31'h0, bus.rd_valid}, 32'd0);
        idle(1);

        // Early abort of a write
        start(1'b0, 10'h040, 16'h1234, 1'b0);
        step(4);
        idle(2);
        rd(10'h040, 16'h0000);

        // Address change mid-read restarts latency
        start(1'b1, 10'h010, 16'h1010, 1'b0);
        step(3);
        bus.sram_addr = 10'h011;
        e.rd = 1'b1; e.cyc = cyc + ACC; e.dat = 16'h1111;
        q.push_back(e);
        step(ACC);
        idle(2);

        // Long hold: single commit
        wr(10'h3FF, 16'hAAAA, 12);
        rd(10'h3FF, 16'hAAAA);

        // Read-to-write turnaround
        start(1'b1, 10'h001, 16'h00C3, 1'b1);
        step(ACC);
        chk("ta_rd_valid", {31'h0, bus.rd_valid}, 32'd1);
        chk("ta_rd_data", {16'h0, sram_dq}, 32'h000000C3);
        bus.sram_we_n = 1'b0;
        step(1);
        tb_oe  = 1'b1;
        tb_dat = 16'h5555;
        #1;
        chk("ta_dq_released", {16'h0, sram_dq}, 32'h00005555);
        chk("ta_rd_valid_low", {31'h0, bus.rd_valid}, 32'd0);
        e.rd = 1'b0; e.cyc = cyc + ACC - 1; e.dat = 16'h5555;
        q.push_back(e);
        step(ACC - 1);
        idle(2);
        rd(10'h001, 16'h5555);

        idle(4);
        chk("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable model of the external asynchronous SRAM device. It is the responder end of the SRAM controller interface.
- Sits on the bench/FPGA side opposite the SRAM controller, which holds address, control and write data stable for a fixed number of wait-state cycles.
- Enforces that same access timing: commits writes and returns read data only after ACCESS_CYCLES cycles of stable request.
- Any early change of the request aborts the access.

Parameters:
- DATA_W, 16, width of the DQ bus and of each memory word.
- ADDR_W, 10, address width; memory depth is 2**ADDR_W words.
- ACCESS_CYCLES, 6, consecutive stable cycles required before write commit or read data drive; legal range 2..7.

Ports:
- clk  input  1  rising-edge clock shared with the controller.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- sram_ce_n  input  1  chip enable, active-low.
- sram_we_n  input  1  write enable, active-low; 1 = read.
- sram_addr  input  ADDR_W  word address.
- sram_dq  inout  DATA_W  bidirectional data; driven only while dq_oe=1, otherwise high-Z.
- rd_valid  output  1  high while read data is being driven on sram_dq.
- acc_done  output  1  one-cycle pulse: write committed, or first cycle of read data.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, dq_oe=0 (sram_dq high-Z), rd_valid=0, acc_done=0. Memory contents are not reset.
- Reset mid-access: no write occurs, and DQ is released immediately (asynchronously).
- Request tuple = {sram_we_n, sram_addr}, latched into req_q when an access starts. "Stable" means sram_ce_n=0 and the current tuple equals req_q.
- States:
  - IDLE: if sram_ce_n=0, latch the tuple, cnt<=1, then go to WR_WAIT (we_n=0) or RD_WAIT (we_n=1).
  - WR_WAIT: each stable cycle cnt<=cnt+1.
    - When cnt==ACCESS_CYCLES-1 and stable: mem[addr] <= sram_dq sampled at that edge; acc_done pulses next cycle; go to WR_HOLD.
  - WR_HOLD: no further writes while stable. This gives exactly one write per access, even if the controller holds the bus longer.
  - RD_WAIT: counts the same way.
    - At cnt==ACCESS_CYCLES-1 and stable: dout_q <= mem[addr], dq_oe<=1, rd_valid<=1, acc_done pulse; go to RD_DRIVE.
  - RD_DRIVE: keep driving dout_q while stable. The value is not re-read, so a write from elsewhere is impossible and there is no hazard.
- Read latency: address is sampled at edge 0; data appears on DQ after edge ACCESS_CYCLES-1, i.e. it is valid in cycle ACCESS_CYCLES-1 counted from the first sampled cycle.
- Write occurs at the (ACCESS_CYCLES-1)th edge after the start edge.
- Abort, from any non-IDLE state:
  - sram_ce_n=1 -> IDLE at the next edge.
  - Tuple change with ce_n=0 -> immediately start the new access (latch, cnt<=1), without passing through IDLE.
  - In both cases dq_oe, rd_valid and acc_done go to 0 at that edge, and no write occurs for the aborted access.
- Bus turnaround: sram_we_n falling while in RD_DRIVE counts as a tuple change. DQ is released at the same edge that starts the write. The controller must not drive DQ before that edge; this is the one-cycle turnaround rule.
- The counter is 3 bits and saturates at its terminal value (never wraps) while in the HOLD/DRIVE states.
- All outputs are registered; sram_dq = dq_oe ? dout_q : 'z.

Decomposition:
- Shared package sram_pkg: state encoding (IDLE, WR_WAIT, WR_HOLD, RD_WAIT, RD_DRIVE), CNT_W=3, and the default ACCESS_CYCLES. The controller uses the same package so both ends agree on timing.
- One sub-module, sram_resp_timer: 3-bit counter with load-to-1, increment-when-stable and terminal-count flag.

Test Plan:
- Reset: hold rst=0 for 3 cycles while ce_n=0 and we_n=0 -> DQ stays high-Z, rd_valid=0 and acc_done=0 throughout; release -> write to addr 0x005 starts cleanly.
- Write then read: write 0xBEEF to addr 0x12A with the request held 6 cycles -> acc_done pulses once. Read 0x12A -> DQ=0xBEEF, first valid in cycle 5, rd_valid=1.
- Early abort: write 0x1234 to addr 0x040, but ce_n goes high after 4 cycles -> no acc_done; a later read of 0x040 returns its previous value (0x0000 after preload).
- Address change mid-read: read 0x010 for 3 cycles, then switch to 0x011 -> latency restarts; data for 0x011 only after 6 further cycles, and 0x010 data is never driven.
- Long hold: write 0xAAAA to 0x3FF held 12 cycles -> exactly one acc_done pulse; a following read returns 0xAAAA.
- Turnaround: read 0x001 until RD_DRIVE, then drop we_n with new data 0x5555 -> DQ goes high-Z at that edge, and the write commits 6 cycles later.
